// File: rtl/bist_if.sv
// bist_if: BIST bus (start + vector ROM fetch in, status/result out) with master (engine) and slave (environment) modports
interface bist_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int IDX_W  = 1
);
  logic                     start;
  logic [IDX_W-1:0]         vec_idx;
  logic                     vec_mode;
  logic signed [DATA_W-1:0] vec_a;
  logic signed [DATA_W-1:0] vec_b;
  logic signed [DATA_W-1:0] vec_c;
  logic signed [ACC_W-1:0]  vec_exp;
  logic                     bist_busy;
  logic                     bist_done;
  logic                     bist_pass;
  logic                     enable_normal;
  logic [IDX_W-1:0]         fail_idx;
  logic [IDX_W:0]           fail_cnt;
  modport master (
    input  start, vec_mode, vec_a, vec_b, vec_c, vec_exp,
    output vec_idx, bist_busy, bist_done, bist_pass, enable_normal, fail_idx, fail_cnt
  );
  modport slave (
    output start, vec_mode, vec_a, vec_b, vec_c, vec_exp,
    input  vec_idx, bist_busy, bist_done, bist_pass, enable_normal, fail_idx, fail_cnt
  );
endinterface

// File: rtl/bist_engine.sv
// bist_engine: vector BIST over one shared signed MAC; ports clk, reset_n (sync active-low), bus (bist_if.master: start/vec_* in, vec_idx/status out)
module bist_engine #(
  parameter int DATA_W       = 8,
  parameter int ACC_W        = 16,
  parameter int NUM_VEC      = 2,
  parameter int IDX_W        = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
  parameter int K_A          = 3,
  parameter int K_B          = 5,
  parameter bit STOP_ON_FAIL = 1'b1,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic   clk,
  input  logic   reset_n,
  bist_if.master bus
);
  localparam int cnt_w = IDX_W + 1;
  localparam logic signed [DATA_W-1:0] k_a = DATA_W'(K_A);
  localparam logic signed [DATA_W-1:0] k_b = DATA_W'(K_B);
  typedef enum logic [2:0] {IDLE, FETCH, OP1, OP2, CHECK, DONE} state_t;
  state_t                   state_q, state_d;
  logic                     first_q, first_d;
  logic                     mode_q, mode_d;
  logic signed [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic signed [ACC_W-1:0]  exp_q, exp_d, acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d, fidx_q, fidx_d;
  logic [cnt_w-1:0]         fcnt_q, fcnt_d;
  logic                     busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic signed [DATA_W-1:0] mul_x, mul_y;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext, c_ext;
  logic                     mism, last, launch, finish, bad;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      first_q <= 1'b1;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      exp_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      fidx_q  <= '0;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      exp_q   <= exp_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      fidx_q  <= fidx_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end
  always_comb begin
    mism   = acc_q != exp_q;
    last   = (mism && STOP_ON_FAIL) || idx_q == IDX_W'(NUM_VEC - 1);
    launch = (state_q == IDLE && (bus.start || (AUTO_START && first_q))) || (state_q == DONE && bus.start);
    finish = state_q == CHECK && last;
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = launch ? FETCH : state_q;
      FETCH:      state_d = OP1;
      OP1:        state_d = OP2;
      OP2:        state_d = CHECK;
      CHECK:      state_d = last ? DONE : FETCH;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    mul_x    = state_q == OP1 ? a_q : b_q;
    mul_y    = !mode_q ? b_q : state_q == OP1 ? k_a : k_b;
    prod     = mul_x * mul_y;
    prod_ext = ACC_W'(prod);
    c_ext    = ACC_W'(c_q);
    bad      = state_q == CHECK && mism;
    first_d  = 1'b0;
    mode_d   = state_q == FETCH ? bus.vec_mode : mode_q;
    a_d      = state_q == FETCH ? bus.vec_a : a_q;
    b_d      = state_q == FETCH ? bus.vec_b : b_q;
    c_d      = state_q == FETCH ? bus.vec_c : c_q;
    exp_d    = state_q == FETCH ? bus.vec_exp : exp_q;
    acc_d    = state_q == OP1 ? prod_ext : state_q == OP2 ? acc_q + (mode_q ? prod_ext : c_ext) : acc_q;
    idx_d    = launch ? '0 : (state_q == CHECK && !last) ? idx_q + IDX_W'(1) : idx_q;
    fcnt_d   = launch ? '0 : (bad && !(&fcnt_q)) ? fcnt_q + cnt_w'(1) : fcnt_q;
    fidx_d   = launch ? '0 : (bad && fcnt_q == '0) ? idx_q : fidx_q;
    busy_d   = launch ? 1'b1 : finish ? 1'b0 : busy_q;
    done_d   = launch ? 1'b0 : finish ? 1'b1 : done_q;
    pass_d   = launch ? 1'b0 : finish ? (fcnt_q == '0 && !mism) : pass_q;
  end
  assign bus.vec_idx       = idx_q;
  assign bus.bist_busy     = busy_q;
  assign bus.bist_done     = done_q;
  assign bus.bist_pass     = pass_q;
  assign bus.enable_normal = pass_q;
  assign bus.fail_idx      = fidx_q;
  assign bus.fail_cnt      = fcnt_q;
endmodule

// File: tb/tb_bist_engine.sv
// tb_bist_engine: directed checks of bist_engine in a 2-vector auto-start/stop-on-fail config and a 4-vector manual-start/run-all config
module tb_bist_engine;
  logic clk = 1'b0;
  logic rn_a = 1'b0, rn_b = 1'b0;
  int n_chk = 0, n_pass = 0;
  logic              ma [2];
  logic signed [7:0] aa [2], ba [2], ca [2];
  logic signed [15:0] ea [2];
  logic              mb [4];
  logic signed [7:0] ab [4], bb [4], cb [4];
  logic signed [15:0] eb [4];
  always #5 clk = ~clk;
  bist_if #(.DATA_W(8), .ACC_W(16), .IDX_W(1)) ia ();
  bist_if #(.DATA_W(8), .ACC_W(16), .IDX_W(2)) ib ();
  assign ia.vec_mode = ma[ia.vec_idx];
  assign ia.vec_a    = aa[ia.vec_idx];
  assign ia.vec_b    = ba[ia.vec_idx];
  assign ia.vec_c    = ca[ia.vec_idx];
  assign ia.vec_exp  = ea[ia.vec_idx];
  assign ib.vec_mode = mb[ib.vec_idx];
  assign ib.vec_a    = ab[ib.vec_idx];
  assign ib.vec_b    = bb[ib.vec_idx];
  assign ib.vec_c    = cb[ib.vec_idx];
  assign ib.vec_exp  = eb[ib.vec_idx];
  bist_engine #(.NUM_VEC(2), .STOP_ON_FAIL(1'b1), .AUTO_START(1'b1)) dut_a (.clk(clk), .reset_n(rn_a), .bus(ia));
  bist_engine #(.NUM_VEC(4), .STOP_ON_FAIL(1'b0), .AUTO_START(1'b0)) dut_b (.clk(clk), .reset_n(rn_b), .bus(ib));
  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask
  task automatic wait_done(input bit s, output int n, output int mx);
    n = 0;
    mx = s ? int'(ib.vec_idx) : int'(ia.vec_idx);
    while (!(s ? ib.bist_done : ia.bist_done) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if ((s ? int'(ib.vec_idx) : int'(ia.vec_idx)) > mx) mx = s ? int'(ib.vec_idx) : int'(ia.vec_idx);
    end
  endtask
  task automatic run_a(input string tag, output int n, output int mx);
    @(negedge clk);
    rn_a = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_rst"}, int'({ia.bist_busy, ia.bist_done, ia.bist_pass, ia.enable_normal, ia.fail_idx, ia.fail_cnt, ia.vec_idx}), 0);
    @(negedge clk);
    rn_a = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_busy"}, int'(ia.bist_busy), 1);
    wait_done(1'b0, n, mx);
  endtask
  task automatic pulse_b();
    @(negedge clk);
    ib.start = 1'b1;
    @(posedge clk);
    #1;
    ib.start = 1'b0;
  endtask
  task automatic set_a(input int i, input bit m, input int a, input int b, input int c, input int e);
    ma[i] = m; aa[i] = 8'(a); ba[i] = 8'(b); ca[i] = 8'(c); ea[i] = 16'(e);
  endtask
  task automatic set_b(input int i, input bit m, input int a, input int b, input int c, input int e);
    mb[i] = m; ab[i] = 8'(a); bb[i] = 8'(b); cb[i] = 8'(c); eb[i] = 16'(e);
  endtask
  initial begin
    int n, mx;
    ia.start = 1'b0;
    ib.start = 1'b0;
    set_a(0, 1'b1, 2, 3, 0, 21);
    set_a(1, 1'b0, -4, 2, 5, -3);
    set_b(0, 1'b1, 2, 3, 0, 21);
    set_b(1, 1'b0, -4, 2, 5, -2);
    set_b(2, 1'b0, 3, 3, 1, 10);
    set_b(3, 1'b1, -1, 1, 0, 0);
    run_a("good", n, mx);
    chk("good_lat", n, 8);
    chk("good_pass", int'(ia.bist_pass), 1);
    chk("good_en", int'(ia.enable_normal), 1);
    chk("good_cnt", int'(ia.fail_cnt), 0);
    chk("good_busy_end", int'(ia.bist_busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("good_hold", int'({ia.bist_done, ia.bist_pass}), 3);
    set_a(1, 1'b0, -4, 2, 5, -2);
    run_a("v1bad", n, mx);
    chk("v1bad_lat", n, 8);
    chk("v1bad_flags", int'({ia.bist_done, ia.bist_pass, ia.enable_normal}), 4);
    chk("v1bad_idx", int'(ia.fail_idx), 1);
    chk("v1bad_cnt", int'(ia.fail_cnt), 1);
    set_a(0, 1'b1, 2, 3, 0, 20);
    set_a(1, 1'b0, -4, 2, 5, -3);
    run_a("v0bad", n, mx);
    chk("v0bad_lat", n, 4);
    chk("v0bad_maxidx", mx, 0);
    chk("v0bad_idx", int'(ia.fail_idx), 0);
    chk("v0bad_cnt", int'(ia.fail_cnt), 1);
    chk("v0bad_pass", int'(ia.bist_pass), 0);
    set_a(0, 1'b0, -128, -128, 127, 16511);
    set_a(1, 1'b1, 127, -128, 0, -259);
    run_a("wrap", n, mx);
    chk("wrap_lat", n, 8);
    chk("wrap_pass", int'(ia.bist_pass), 1);
    chk("wrap_cnt", int'(ia.fail_cnt), 0);
    @(negedge clk);
    rn_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("b_noauto", int'({ib.bist_busy, ib.bist_done}), 0);
    pulse_b();
    chk("b_busy", int'(ib.bist_busy), 1);
    repeat (6) @(posedge clk);
    pulse_b();
    chk("b_ign_idx", int'(ib.vec_idx), 1);
    chk("b_ign_busy", int'(ib.bist_busy), 1);
    @(negedge clk);
    rn_b = 1'b0;
    @(posedge clk);
    #1;
    chk("b_midrst", int'({ib.bist_busy, ib.bist_done, ib.bist_pass, ib.enable_normal, ib.fail_idx, ib.fail_cnt, ib.vec_idx}), 0);
    @(negedge clk);
    rn_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("b_idle", int'(ib.bist_busy), 0);
    pulse_b();
    wait_done(1'b1, n, mx);
    chk("b_lat", n, 16);
    chk("b_maxidx", mx, 3);
    chk("b_flags", int'({ib.bist_busy, ib.bist_pass, ib.enable_normal}), 0);
    chk("b_fidx", int'(ib.fail_idx), 1);
    chk("b_fcnt", int'(ib.fail_cnt), 2);
    pulse_b();
    chk("b_re_clr", int'({ib.bist_busy, ib.bist_done, ib.fail_cnt}), 16);
    wait_done(1'b1, n, mx);
    chk("b_re_lat", n, 16);
    chk("b_re_fidx", int'(ib.fail_idx), 1);
    chk("b_re_fcnt", int'(ib.fail_cnt), 2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bist_engine.md
Name: bist_engine

Overview:
- Parametrised, vector-driven built-in self-test controller. It runs NUM_VEC test vectors through one shared signed multiplier/accumulator and compares each result to an expected value.
- Supports two operation modes per vector (MAC and weighted sum), optional stop-on-first-fail, restart on demand, and reports the first failing index and a fail count.
- Sits between reset release and the mission datapath. enable_normal gates normal operation.

Parameters:
DATA_W, 8, signed operand width (a, b, c)
ACC_W, 16, signed accumulator/expected-value width; must be >= 2*DATA_W
NUM_VEC, 2, number of test vectors (>=1)
IDX_W, $clog2(NUM_VEC) (min 1), vector index width
K_A, 3, signed weight applied to a in mode 1
K_B, 5, signed weight applied to b in mode 1
STOP_ON_FAIL, 1, 1 = end run on first mismatch; 0 = run all vectors
AUTO_START, 1, 1 = start a run automatically on the first cycle out of reset

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  pulse; begins a run when not busy
vec_idx  out  IDX_W  index of the vector being fetched (vector ROM address)
vec_mode  in  1  0 = a*b + c, 1 = a*K_A + b*K_B
vec_a  in  DATA_W  signed operand a, valid combinationally for vec_idx
vec_b  in  DATA_W  signed operand b
vec_c  in  DATA_W  signed operand c (ignored in mode 1)
vec_exp  in  ACC_W  signed expected result
bist_busy  out  1  high while a run is in progress
bist_done  out  1  high when the run has completed; held until the next run starts or reset
bist_pass  out  1  high only if the completed run had zero mismatches
enable_normal  out  1  equals bist_pass once done; 0 otherwise
fail_idx  out  IDX_W  index of the first failing vector (0 if none)
fail_cnt  out  IDX_W+1  number of failing vectors, saturating

Behaviour:
- Reset (reset_n=0 at clk edge):
  - state=IDLE; vec_idx=0.
  - All outputs 0; internal accumulator 0.
  - Reset mid-run aborts the run immediately, with no partial flags.
- States: IDLE, FETCH, OP1, OP2, CHECK, DONE.
- IDLE:
  - Goes to FETCH on start=1, or on the first cycle after reset when AUTO_START=1.
  - On entry to FETCH: busy=1; done, pass and enable_normal cleared; fail_cnt=0, fail_idx=0; vec_idx=0.
- FETCH: latch vec_mode, vec_a, vec_b, vec_c and vec_exp into registers; go to OP1.
- OP1 (uses the shared multiplier):
  - mode 0: acc <= a*b.
  - mode 1: acc <= a*K_A.
- OP2 (shared multiplier reused, at most one multiply per cycle):
  - mode 0: acc <= acc + sext(c).
  - mode 1: acc <= acc + b*K_B.
- Arithmetic: all signed; products sign-extended to ACC_W; sums wrap modulo 2^ACC_W with no saturation.
- CHECK: compare acc against the latched vec_exp (full ACC_W).
  - On mismatch: fail_cnt increments (saturates at all-ones). fail_idx <= vec_idx only if this is the first failure of the run.
  - Run ends when (mismatch and STOP_ON_FAIL=1) or vec_idx==NUM_VEC-1.
    - Same edge: go to DONE; busy=0; done=1; pass = (no mismatches, including the current one); enable_normal = pass.
  - Otherwise: vec_idx increments and the state goes to FETCH.
- Latency: 4 cycles per vector. bist_done rises 4*N clock edges after the start-accept edge, where N = vectors executed.
- DONE:
  - Outputs hold.
  - start=1 restarts the run (same actions as leaving IDLE).
- Busy behaviour: start is ignored while busy. No wrap of vec_idx beyond NUM_VEC-1.
- vec_* inputs are only sampled in FETCH; they may change at any other time.

Test Plan:
- NUM_VEC=2, AUTO_START=1. Vec0 = mode1, a=2, b=3, exp=21. Vec1 = mode0, a=-4, b=2, c=5, exp=-3. Release reset.
  -> bist_done and bist_pass rise 8 edges after the first post-reset edge; enable_normal=1, fail_cnt=0.
- Same vectors, but vec1 exp=-2, STOP_ON_FAIL=1.
  -> done=1, pass=0, enable_normal=0, fail_idx=1, fail_cnt=1.
- NUM_VEC=4, STOP_ON_FAIL=0, vectors 1 and 3 wrong.
  -> all 4 vectors run (done at 16 edges); fail_idx=1, fail_cnt=2.
- STOP_ON_FAIL=1, vec0 wrong.
  -> done after 4 edges; vec_idx never reaches 1; fail_idx=0, fail_cnt=1.
- Pulse start mid-run (ignored); then reset_n=0 mid-run.
  -> all outputs 0 next edge. Release reset with AUTO_START=0 and pulse start -> clean full run; then pulse start in DONE -> flags clear and the run repeats.
- Wrap check, mode0, a=-128, b=-128, c=127, exp=16511.
  -> pass; with ACC_W=16, mode1 a=127 yields acc=381+b*5 as expected.
